// File: rtl/pipe_pkg.sv
// Shared types for the EX->MEM->WB register bank: memory access codes,
// default-width lane bundles, the r0 address constant and a popcount helper.
package pipe_pkg;

    localparam int unsigned MEM_TYPE_W = 3;

    typedef enum logic [MEM_TYPE_W-1:0] {
        MEM_NONE = 3'd0,
        MEM_LB   = 3'd1,
        MEM_LH   = 3'd2,
        MEM_LW   = 3'd3,
        MEM_SB   = 3'd4,
        MEM_SH   = 3'd5,
        MEM_SW   = 3'd6,
        MEM_LLSC = 3'd7
    } mem_type_e;

    localparam int unsigned LANE_DATA_W  = 32;
    localparam int unsigned LANE_RADDR_W = 5;
    localparam int unsigned LANE_SEL_W   = 6;

    // Architectural zero register; writes to it are dropped.
    localparam int unsigned RADDR_ZERO = 0;

    typedef struct packed {
        logic                    valid;
        logic                    br_redirect;
        logic                    rf_we;
        logic [LANE_RADDR_W-1:0] rf_waddr;
        logic [LANE_DATA_W-1:0]  result;
        logic [LANE_SEL_W-1:0]   wb_sel;
        mem_type_e               mem_type;
    } lane_ex_t;

    typedef struct packed {
        logic                    valid;
        logic                    rf_we;
        logic [LANE_RADDR_W-1:0] rf_waddr;
        logic [LANE_DATA_W-1:0]  result;
        logic [LANE_SEL_W-1:0]   wb_sel;
        mem_type_e               mem_type;
    } lane_mem_t;

    typedef struct packed {
        logic                    valid;
        logic                    rf_we;
        logic [LANE_RADDR_W-1:0] rf_waddr;
        logic [LANE_DATA_W-1:0]  rf_wdata;
    } lane_wb_t;

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_kill_mask.sv
// Kill mask for younger lanes: lane j is killed when any older lane i<j
// is valid and redirects fetch. Ports: valid_i, redirect_i -> kill_o.
module pipe_kill_mask #(
    parameter int unsigned NUM_LANES = 2
) (
    input  logic [NUM_LANES-1:0] valid_i,
    input  logic [NUM_LANES-1:0] redirect_i,
    output logic [NUM_LANES-1:0] kill_o
);

    logic acc;

    // Exclusive prefix-OR: a redirecting lane kills only lanes after it.
    always_comb begin
        acc    = 1'b0;
        kill_o = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            kill_o[j] = acc;
            acc       = acc | (valid_i[j] & redirect_i[j]);
        end
    end

endmodule

// File: rtl/pipe_stage_regs_multi.sv
// N-lane EX->MEM->WB pipeline register bank with redirect kill, flush,
// OR-reduced stall and r0 write gating. Ports: EX-side lane fields and
// mem_wdata in; MEM and WB stage fields out; stall_cnt/kill_cnt perf
// counters exist only with PIPE_PERF_CNT_EN defined (else tied to 0).
module pipe_stage_regs_multi
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RADDR_W    = 5,
    parameter int unsigned SEL_W      = 6,
    parameter int unsigned STALL_SRCS = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [STALL_SRCS-1:0]           stall,
    input  logic                            flush,
    input  logic [NUM_LANES-1:0]            ex_valid,
    input  logic [NUM_LANES-1:0]            ex_br_redirect,
    input  logic [NUM_LANES-1:0]            ex_rf_we,
    input  logic [NUM_LANES*RADDR_W-1:0]    ex_rf_waddr,
    input  logic [NUM_LANES*DATA_W-1:0]     ex_result,
    input  logic [NUM_LANES*SEL_W-1:0]      ex_wb_sel,
    input  logic [NUM_LANES*MEM_TYPE_W-1:0] ex_mem_type,
    input  logic [NUM_LANES*DATA_W-1:0]     mem_wdata,
    output logic [NUM_LANES-1:0]            mem_valid,
    output logic [NUM_LANES-1:0]            mem_rf_we,
    output logic [NUM_LANES*RADDR_W-1:0]    mem_rf_waddr,
    output logic [NUM_LANES*DATA_W-1:0]     mem_result,
    output logic [NUM_LANES*SEL_W-1:0]      mem_wb_sel,
    output logic [NUM_LANES*MEM_TYPE_W-1:0] mem_mem_type,
    output logic [NUM_LANES-1:0]            wb_valid,
    output logic [NUM_LANES-1:0]            wb_rf_we,
    output logic [NUM_LANES*RADDR_W-1:0]    wb_rf_waddr,
    output logic [NUM_LANES*DATA_W-1:0]     wb_rf_wdata,
    output logic [CNT_W-1:0]                stall_cnt,
    output logic [CNT_W-1:0]                kill_cnt
);

    localparam int unsigned MT = MEM_TYPE_W;

    logic                         adv;
    logic [NUM_LANES-1:0]         kill;
    logic [NUM_LANES-1:0]         live;

    logic [NUM_LANES-1:0]         mem_valid_q, mem_valid_d;
    logic [NUM_LANES-1:0]         mem_rf_we_q, mem_rf_we_d;
    logic [NUM_LANES*RADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [NUM_LANES*DATA_W-1:0]  mem_result_q, mem_result_d;
    logic [NUM_LANES*SEL_W-1:0]   mem_wb_sel_q, mem_wb_sel_d;
    logic [NUM_LANES*MT-1:0]      mem_type_q, mem_type_d;
    logic [NUM_LANES-1:0]         wb_valid_q, wb_valid_d;
    logic [NUM_LANES-1:0]         wb_rf_we_q, wb_rf_we_d;
    logic [NUM_LANES*RADDR_W-1:0] wb_waddr_q, wb_waddr_d;
    logic [NUM_LANES*DATA_W-1:0]  wb_wdata_q, wb_wdata_d;

    assign adv  = ~|stall;
    assign live = ex_valid & ~kill;

    pipe_kill_mask #(
        .NUM_LANES (NUM_LANES)
    ) u_kill_mask (
        .valid_i    (ex_valid),
        .redirect_i (ex_br_redirect),
        .kill_o     (kill)
    );

    // EX->MEM. Flush beats stall; it clears only the control bits, leaving
    // MEM data as-is. The write address loads even for dead lanes.
    always_comb begin
        mem_valid_d  = mem_valid_q;
        mem_rf_we_d  = mem_rf_we_q;
        mem_waddr_d  = mem_waddr_q;
        mem_result_d = mem_result_q;
        mem_wb_sel_d = mem_wb_sel_q;
        mem_type_d   = mem_type_q;
        if (flush) begin
            mem_valid_d = '0;
            mem_rf_we_d = '0;
            mem_type_d  = '0;
        end else if (adv) begin
            mem_valid_d = live;
            for (int i = 0; i < NUM_LANES; i++) begin
                mem_waddr_d[i*RADDR_W +: RADDR_W] =
                    ex_rf_waddr[i*RADDR_W +: RADDR_W];
                mem_rf_we_d[i] = live[i] & ex_rf_we[i] &
                    (ex_rf_waddr[i*RADDR_W +: RADDR_W] !=
                     RADDR_W'(RADDR_ZERO));
                mem_result_d[i*DATA_W +: DATA_W] = live[i] ?
                    ex_result[i*DATA_W +: DATA_W] : '0;
                mem_wb_sel_d[i*SEL_W +: SEL_W] = live[i] ?
                    ex_wb_sel[i*SEL_W +: SEL_W] : '0;
                mem_type_d[i*MT +: MT] = live[i] ?
                    ex_mem_type[i*MT +: MT] : MEM_NONE;
            end
        end
    end

    // MEM->WB. A stalled WB re-presents the same write, so holding is safe.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rf_we_d = wb_rf_we_q;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        if (adv) begin
            wb_valid_d = mem_valid_q & ~{NUM_LANES{flush}};
            wb_rf_we_d = mem_rf_we_q & ~{NUM_LANES{flush}};
            wb_waddr_d = mem_waddr_q;
            wb_wdata_d = mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q  <= '0;
            mem_rf_we_q  <= '0;
            mem_waddr_q  <= '0;
            mem_result_q <= '0;
            mem_wb_sel_q <= '0;
            mem_type_q   <= '0;
            wb_valid_q   <= '0;
            wb_rf_we_q   <= '0;
            wb_waddr_q   <= '0;
            wb_wdata_q   <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            mem_rf_we_q  <= mem_rf_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_result_q <= mem_result_d;
            mem_wb_sel_q <= mem_wb_sel_d;
            mem_type_q   <= mem_type_d;
            wb_valid_q   <= wb_valid_d;
            wb_rf_we_q   <= wb_rf_we_d;
            wb_waddr_q   <= wb_waddr_d;
            wb_wdata_q   <= wb_wdata_d;
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_rf_we    = mem_rf_we_q;
    assign mem_rf_waddr = mem_waddr_q;
    assign mem_result   = mem_result_q;
    assign mem_wb_sel   = mem_wb_sel_q;
    assign mem_mem_type = mem_type_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rf_we     = wb_rf_we_q;
    assign wb_rf_waddr  = wb_waddr_q;
    assign wb_rf_wdata  = wb_wdata_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic [CNT_W:0]   kill_sum;
    logic [31:0]      dropped;

    // Lanes that were valid in EX but did not reach MEM this edge.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        dropped     = popcount(32'(ex_valid & (kill | {NUM_LANES{flush}})));
        kill_sum    = {1'b0, kill_cnt_q} + (CNT_W+1)'(dropped);
        if (!adv && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (adv || flush) begin
            kill_cnt_d = kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign kill_cnt  = kill_cnt_q;
`else
    assign stall_cnt = '0;
    assign kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs_multi.sv
// Self-checking bench for pipe_stage_regs_multi: 2-lane DUT against a
// queued reference model, plus a 4-lane/4-bit-counter DUT.
module tb_pipe_stage_regs_multi;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]  stall;
    logic        flush;
    logic [1:0]  ex_valid, ex_br_redirect, ex_rf_we;
    logic [9:0]  ex_rf_waddr;
    logic [63:0] ex_result;
    logic [11:0] ex_wb_sel;
    logic [5:0]  ex_mem_type;
    logic [63:0] mem_wdata;
    logic [1:0]  mem_valid, mem_rf_we, wb_valid, wb_rf_we;
    logic [9:0]  mem_rf_waddr, wb_rf_waddr;
    logic [63:0] mem_result, wb_rf_wdata;
    logic [11:0] mem_wb_sel;
    logic [5:0]  mem_mem_type;
    logic [31:0] stall_cnt, kill_cnt;

    logic [3:0]   ex4_valid, ex4_br_redirect, ex4_rf_we;
    logic [19:0]  ex4_rf_waddr;
    logic [127:0] ex4_result, mem4_wdata;
    logic [23:0]  ex4_wb_sel;
    logic [11:0]  ex4_mem_type;
    logic [3:0]   m4_valid, m4_rf_we, w4_valid, w4_rf_we;
    logic [19:0]  m4_rf_waddr, w4_rf_waddr;
    logic [127:0] m4_result, w4_rf_wdata;
    logic [23:0]  m4_wb_sel;
    logic [11:0]  m4_mem_type;
    logic [3:0]   stall_cnt4, kill_cnt4;

    typedef struct packed {
        logic [1:0]  mv, mwe;
        logic [9:0]  mwa;
        logic [63:0] mres;
        logic [11:0] msel;
        logic [5:0]  mmt;
        logic [1:0]  wv, wwe;
        logic [9:0]  wwa;
        logic [63:0] wwd;
    } exp_t;

    exp_t mdl;
    exp_t e;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [63:0] keep;

    always #5 clk = ~clk;

    pipe_stage_regs_multi dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_br_redirect(ex_br_redirect),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_result(ex_result), .ex_wb_sel(ex_wb_sel),
        .ex_mem_type(ex_mem_type), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_rf_we(mem_rf_we),
        .mem_rf_waddr(mem_rf_waddr), .mem_result(mem_result),
        .mem_wb_sel(mem_wb_sel), .mem_mem_type(mem_mem_type),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we),
        .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
        .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
    );

    pipe_stage_regs_multi #(.NUM_LANES(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex4_valid), .ex_br_redirect(ex4_br_redirect),
        .ex_rf_we(ex4_rf_we), .ex_rf_waddr(ex4_rf_waddr),
        .ex_result(ex4_result), .ex_wb_sel(ex4_wb_sel),
        .ex_mem_type(ex4_mem_type), .mem_wdata(mem4_wdata),
        .mem_valid(m4_valid), .mem_rf_we(m4_rf_we),
        .mem_rf_waddr(m4_rf_waddr), .mem_result(m4_result),
        .mem_wb_sel(m4_wb_sel), .mem_mem_type(m4_mem_type),
        .wb_valid(w4_valid), .wb_rf_we(w4_rf_we),
        .wb_rf_waddr(w4_rf_waddr), .wb_rf_wdata(w4_rf_wdata),
        .stall_cnt(stall_cnt4), .kill_cnt(kill_cnt4)
    );

    function automatic exp_t snap();
        return {mem_valid, mem_rf_we, mem_rf_waddr, mem_result, mem_wb_sel,
                mem_mem_type, wb_valid, wb_rf_we, wb_rf_waddr, wb_rf_wdata};
    endfunction

    // Reference model: next state from the currently driven inputs.
    task automatic predict();
        exp_t n;
        logic adv, k, live;
        logic [1:0] kl;
        adv = ~|stall;
        n = mdl;
        k = 1'b0;
        for (int j = 0; j < 2; j++) begin
            kl[j] = k;
            k = k | (ex_valid[j] & ex_br_redirect[j]);
        end
        if (adv) begin
            n.wv  = mdl.mv & ~{2{flush}};
            n.wwe = mdl.mwe & ~{2{flush}};
            n.wwa = mdl.mwa;
            n.wwd = mem_wdata;
        end
        if (flush) begin
            n.mv = '0; n.mwe = '0; n.mmt = '0;
        end else if (adv) begin
            for (int j = 0; j < 2; j++) begin
                live = ex_valid[j] & ~kl[j];
                n.mv[j] = live;
                n.mwa[j*5 +: 5] = ex_rf_waddr[j*5 +: 5];
                n.mwe[j] = live & ex_rf_we[j] & (ex_rf_waddr[j*5 +: 5] != 5'd0);
                n.mres[j*32 +: 32] = live ? ex_result[j*32 +: 32] : 32'd0;
                n.msel[j*6 +: 6] = live ? ex_wb_sel[j*6 +: 6] : 6'd0;
                n.mmt[j*3 +: 3] = live ? ex_mem_type[j*3 +: 3] : 3'd0;
            end
        end
        sb.push_back(n);
        mdl = n;
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic idle();
        stall = '0; flush = 1'b0;
        ex_valid = '0; ex_br_redirect = '0; ex_rf_we = '0;
        ex_rf_waddr = '0; ex_result = '0; ex_wb_sel = '0;
        ex_mem_type = '0; mem_wdata = '0;
        ex4_valid = '0; ex4_br_redirect = '0; ex4_rf_we = '0;
        ex4_rf_waddr = '0; ex4_result = '0; ex4_wb_sel = '0;
        ex4_mem_type = '0; mem4_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 2'($urandom); flush = 1'($urandom);
        ex_valid = 2'($urandom); ex_br_redirect = 2'($urandom);
        ex_rf_we = 2'b11; ex_rf_waddr = 10'($urandom);
        ex_result = {$urandom, $urandom}; ex_wb_sel = 12'($urandom);
        ex_mem_type = 6'($urandom); mem_wdata = {$urandom, $urandom};
        ex4_valid = 4'hF; ex4_rf_we = 4'hF; ex4_br_redirect = '0;
        ex4_rf_waddr = 20'($urandom); ex4_result = '1; ex4_wb_sel = '1;
        ex4_mem_type = '1; mem4_wdata = '1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (snap() !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got %h exp 0", snap());
        end
        n_checks++;
        if ({m4_valid, m4_result, w4_rf_wdata, stall_cnt, kill_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_aux got m4v=%b sc=%0d kc=%0d exp 0",
                     m4_valid, stall_cnt, kill_cnt);
        end
        idle();
        rst = 1'b0;
        mdl = '0;
        sb.delete();
        ex_valid = 2'b11; ex_rf_we = 2'b11;
        ex_rf_waddr = {5'd4, 5'd3};
        ex_result = {32'hB0B0_0001, 32'hA0A0_0001};
        step();
        n_checks++;
        if (mem_valid !== 2'b11 || mem_rf_waddr !== {5'd4, 5'd3}) begin
            n_errors++;
            $display("FAIL first_capture got v=%b wa=%h exp v=11 wa=%h",
                     mem_valid, mem_rf_waddr, {5'd4, 5'd3});
        end
        idle();
        mem_wdata = {32'h1111_2222, 32'h3333_4444};
        step();
        n_checks++;
        if (wb_valid !== 2'b11 || wb_rf_we !== 2'b11 ||
            wb_rf_waddr !== {5'd4, 5'd3} ||
            wb_rf_wdata !== {32'h1111_2222, 32'h3333_4444}) begin
            n_errors++;
            $display("FAIL first_wb got v=%b we=%b wa=%h wd=%h",
                     wb_valid, wb_rf_we, wb_rf_waddr, wb_rf_wdata);
        end
    endtask

    task automatic test_redirect();
        idle();
        ex_valid = 2'b11; ex_br_redirect = 2'b01; ex_rf_we = 2'b11;
        ex_rf_waddr = {5'd6, 5'd5};
        ex_result = {32'h2222_2222, 32'h1111_1111};
        ex_wb_sel = {6'd9, 6'd3}; ex_mem_type = {3'd6, 3'd3};
        ex4_valid = 4'hF; ex4_br_redirect = 4'b0010; ex4_rf_we = 4'hF;
        ex4_rf_waddr = {5'd4, 5'd3, 5'd2, 5'd1};
        step();
        n_checks++;
        if (mem_valid !== 2'b01 || mem_rf_we !== 2'b01) begin
            n_errors++;
            $display("FAIL redirect_ctrl got v=%b we=%b exp v=01 we=01",
                     mem_valid, mem_rf_we);
        end
        n_checks++;
        if (mem_result !== {32'h0, 32'h1111_1111} ||
            mem_mem_type !== {3'd0, 3'd3} || mem_wb_sel !== {6'd0, 6'd3}) begin
            n_errors++;
            $display("FAIL redirect_data got r=%h mt=%h sel=%h",
                     mem_result, mem_mem_type, mem_wb_sel);
        end
        n_checks++;
        if (mem_rf_waddr !== {5'd6, 5'd5}) begin
            n_errors++;
            $display("FAIL redirect_waddr got %h exp %h",
                     mem_rf_waddr, {5'd6, 5'd5});
        end
        n_checks++;
        if (m4_valid !== 4'b0011 || m4_rf_we !== 4'b0011) begin
            n_errors++;
            $display("FAIL redirect4 got v=%b we=%b exp 0011", m4_valid, m4_rf_we);
        end
    endtask

    task automatic test_stall();
        idle();
        ex_valid = 2'b11; ex_rf_we = 2'b11; ex_rf_waddr = {5'd8, 5'd7};
        ex_result = {32'hAAAA_0002, 32'hAAAA_0001};
        mem_wdata = {32'hC0DE_0002, 32'hC0DE_0001};
        step();
        keep = mem_result;
        for (int c = 0; c < 3; c++) begin
            stall = 2'b10;
            ex_valid = 2'($urandom); ex_result = {$urandom, $urandom};
            ex_rf_waddr = 10'($urandom); mem_wdata = {$urandom, $urandom};
            step();
            n_checks++;
            if (mem_result !== keep || snap() !== e) begin
                n_errors++;
                $display("FAIL stall_hold c=%0d got %h exp %h", c, snap(), e);
            end
        end
        stall = 2'b00; ex_valid = 2'b11; ex_br_redirect = '0;
        ex_result = {32'hBBBB_0002, 32'hBBBB_0001};
        step();
        n_checks++;
        if (mem_result !== {32'hBBBB_0002, 32'hBBBB_0001} || mem_valid !== 2'b11) begin
            n_errors++;
            $display("FAIL stall_release got r=%h v=%b", mem_result, mem_valid);
        end
    endtask

    task automatic test_flush_stall();
        idle();
        ex_valid = 2'b11; ex_rf_we = 2'b11; ex_rf_waddr = {5'd2, 5'd1};
        ex_result = {32'h5, 32'h6};
        step();
        stall = 2'b01; flush = 1'b1;
        step();
        n_checks++;
        if (mem_valid !== 2'b00 || mem_rf_we !== 2'b00 ||
            mem_mem_type !== '0 || wb_valid !== 2'b11) begin
            n_errors++;
            $display("FAIL flush_stall got mv=%b mwe=%b wv=%b exp mv=00 wv=11",
                     mem_valid, mem_rf_we, wb_valid);
        end
        n_checks++;
        if (mem_result !== {32'h5, 32'h6}) begin
            n_errors++;
            $display("FAIL flush_data got %h exp %h", mem_result, {32'h5, 32'h6});
        end
        flush = 1'b0;
        step();
        n_checks++;
        if (wb_valid !== 2'b11 || mem_valid !== 2'b00) begin
            n_errors++;
            $display("FAIL flush_hold got wv=%b mv=%b exp 11/00", wb_valid, mem_valid);
        end
        stall = 2'b00; ex_valid = '0;
        step();
        n_checks++;
        if (wb_valid !== 2'b00 || wb_rf_we !== 2'b00) begin
            n_errors++;
            $display("FAIL flush_drain got wv=%b we=%b exp 00", wb_valid, wb_rf_we);
        end
    endtask

    task automatic test_r0();
        idle();
        ex_valid = 2'b01; ex_rf_we = 2'b01; ex_rf_waddr = '0;
        ex_result = {32'h0, 32'hDEAD_BEEF};
        step();
        n_checks++;
        if (mem_rf_we !== 2'b00 || mem_valid !== 2'b01 ||
            mem_result[31:0] !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL r0_mem got we=%b v=%b r=%h", mem_rf_we, mem_valid,
                     mem_result[31:0]);
        end
        idle();
        mem_wdata = {32'h0, 32'hDEAD_BEEF};
        step();
        n_checks++;
        if (wb_rf_we !== 2'b00 || wb_valid !== 2'b01 ||
            wb_rf_waddr[4:0] !== 5'd0 || wb_rf_wdata[31:0] !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL r0_wb got we=%b v=%b wa=%h wd=%h", wb_rf_we, wb_valid,
                     wb_rf_waddr[4:0], wb_rf_wdata[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            stall = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            flush = ($urandom_range(0, 7) == 0);
            ex_valid = 2'($urandom); ex_br_redirect = 2'($urandom);
            ex_rf_we = 2'($urandom);
            ex_rf_waddr = {5'($urandom_range(0, 2)), 5'($urandom_range(0, 2))};
            ex_result = {$urandom, $urandom}; ex_wb_sel = 12'($urandom);
            ex_mem_type = 6'($urandom); mem_wdata = {$urandom, $urandom};
            step();
            n_checks++;
            if (snap() !== e) begin
                n_errors++;
                $display("FAIL b2b c=%0d got %h exp %h", c, snap(), e);
            end
        end
    endtask

    task automatic test_perf();
        ex_valid = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_valid !== 2'b00 || wb_valid !== 2'b00 || wb_rf_we !== 2'b00) begin
            n_errors++;
            $display("FAIL async_rst got mv=%b wv=%b exp 00", mem_valid, wb_valid);
        end
        @(posedge clk);
        #1;
        idle();
        rst = 1'b0;
        mdl = '0;
        sb.delete();
        stall = 2'b01;
        repeat (5) step();
        stall = 2'b00; ex_valid = 2'b11; ex_br_redirect = 2'b01;
        step();
        idle();
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd5 || kill_cnt !== 32'd1) begin
            n_errors++;
            $display("FAIL perf_counts got sc=%0d kc=%0d exp 5/1", stall_cnt, kill_cnt);
        end
        stall = 2'b10;
        repeat (20) step();
        n_checks++;
        if (stall_cnt4 !== 4'hF || stall_cnt !== 32'd25 || kill_cnt4 !== 4'd0) begin
            n_errors++;
            $display("FAIL perf_sat got sc4=%0d sc=%0d kc4=%0d exp 15/25/0",
                     stall_cnt4, stall_cnt, kill_cnt4);
        end
`else
        stall = 2'b10;
        repeat (3) step();
        n_checks++;
        if (stall_cnt !== '0 || kill_cnt !== '0 || stall_cnt4 !== '0) begin
            n_errors++;
            $display("FAIL perf_off got sc=%0d kc=%0d exp 0", stall_cnt, kill_cnt);
        end
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_stall();
        test_flush_stall();
        test_r0();
        test_back_to_back();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
